// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit states, default timing constants, frame helpers.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    ACK,
    RELEASE
  } ps2_state_e;

  localparam int unsigned PS2_INHIBIT_CYCLES = 5000;
  localparam int unsigned PS2_TIMEOUT_CYCLES = 750000;
  localparam int unsigned PS2_IDX_W          = 4;

  function automatic int unsigned ps2_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Frame bit at index: 0-7 data LSB first, 8 parity, 9 stop.
  function automatic logic ps2_frame_bit(input logic [7:0] data, input logic parity,
                                         input logic [PS2_IDX_W-1:0] idx);
    if (idx < PS2_IDX_W'(8)) begin
      return data[idx[2:0]];
    end else if (idx == PS2_IDX_W'(8)) begin
      return parity;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a 1->0 edge detect on the synchronized level.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic fall_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines float high, so every stage resets to 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_c  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 10 device-clocked bits, ACK, bus release.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned MAX_CYCLES = ps2_max(INHIBIT_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned IDX_W      = PS2_IDX_W;

  ps2_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       data_q;
  logic             par_q;
  logic             nak_q;
  logic             tx_ready_q;
  logic             clk_oe_q;
  logic             dat_oe_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             clk_lvl;
  logic             clk_fall_c;
  logic             dat_lvl;
  logic             dat_fall_unused;
  logic             timeout_c;

  ps2_line_sync u_clk_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .line_i  (ps2_clk_in),
    .level_o (clk_lvl),
    .fall_c  (clk_fall_c)
  );

  ps2_line_sync u_dat_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .line_i  (ps2_dat_in),
    .level_o (dat_lvl),
    .fall_c  (dat_fall_unused)
  );

  // Device-paced states abort once the gap since the last edge or state entry hits the limit.
  assign timeout_c = (state_q != IDLE) && (state_q != INHIBIT) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      nak_q      <= 1'b0;
      tx_ready_q <= 1'b1;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (timeout_c) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        clk_oe_q   <= 1'b0;
        dat_oe_q   <= 1'b0;
        tx_ready_q <= 1'b1;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        err_q      <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (tx_valid && tx_ready_q) begin
              state_q    <= INHIBIT;
              data_q     <= tx_data;
              par_q      <= ~^tx_data;
              nak_q      <= 1'b0;
              cnt_q      <= '0;
              tx_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              clk_oe_q   <= 1'b1;
              dat_oe_q   <= (INHIBIT_CYCLES <= 1);
            end
          end
          INHIBIT: begin
            if (cnt_q >= CNT_W'(INHIBIT_CYCLES - 1)) begin
              state_q  <= START;
              cnt_q    <= '0;
              clk_oe_q <= 1'b0;
              dat_oe_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              // Start bit goes onto the bus during the final inhibit cycle.
              if ((INHIBIT_CYCLES >= 2) && (cnt_q == CNT_W'(INHIBIT_CYCLES - 2))) begin
                dat_oe_q <= 1'b1;
              end
            end
          end
          START: begin
            if (clk_fall_c) begin
              state_q  <= BITS;
              idx_q    <= '0;
              cnt_q    <= '0;
              dat_oe_q <= ~data_q[0];
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          BITS: begin
            if (clk_fall_c) begin
              cnt_q <= '0;
              if (idx_q == IDX_W'(9)) begin
                state_q  <= ACK;
                nak_q    <= dat_lvl;
                dat_oe_q <= 1'b0;
              end else begin
                idx_q    <= idx_q + IDX_W'(1);
                dat_oe_q <= ~ps2_frame_bit(data_q, par_q, idx_q + IDX_W'(1));
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ACK: begin
            state_q <= RELEASE;
            cnt_q   <= '0;
          end
          RELEASE: begin
            if (clk_lvl && dat_lvl) begin
              state_q    <= IDLE;
              cnt_q      <= '0;
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              err_q      <= nak_q;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q  <= IDLE;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_ready   = tx_ready_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a 40-cycle-period device clock model.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 10;
  localparam int unsigned TMO  = 200;
  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic       dev_clk;
  logic       dev_dat;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Open-drain lines with pull-ups: low if either side pulls.
  assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
  assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit hold);
    int w;
    w = 0;
    while (!tx_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Counts cycles with the clock line pulled and the cycle the start bit first appears.
  task automatic inhibit_phase(output int n_oe, output int first_dat);
    int w;
    w         = 0;
    n_oe      = 0;
    first_dat = 0;
    while (!ps2_clk_oe && w < 100) begin
      @(negedge clk);
      w++;
    end
    while (ps2_clk_oe && n_oe < 1000) begin
      n_oe++;
      if (ps2_dat_oe && first_dat == 0) first_dat = n_oe;
      @(negedge clk);
    end
  endtask

  // Device clock generator; samples the data line on each rising edge.
  task automatic dev_clock(input int nfalls, input bit ack, output logic [9:0] bits);
    bits = '0;
    cycles(HALF);
    for (int k = 1; k <= nfalls; k++) begin
      dev_clk = 1'b0;
      cycles(HALF);
      dev_clk = 1'b1;
      if (k <= 10) bits[k-1] = ~ps2_dat_oe & dev_dat;
      if (k == 11) begin
        dev_dat = 1'b1;
      end else if (k == 10) begin
        cycles(HALF / 2);
        dev_dat = ack ? 1'b0 : 1'b1;
        cycles(HALF / 2);
      end else begin
        cycles(HALF);
      end
    end
  endtask

  task automatic wait_done(input int bound, output bit seen, output logic errv, output int waited);
    seen   = 1'b0;
    errv   = 1'b0;
    waited = 0;
    while (!seen && waited < bound) begin
      @(negedge clk);
      waited++;
      if (done) begin
        seen = 1'b1;
        errv = err;
      end
    end
  endtask

  task automatic finish_checks(input string pfx, input logic [9:0] bits, input logic [9:0] exp_bits,
                               input bit exp_err);
    bit         seen;
    logic       errv;
    int         waited;
    check_eq({pfx, "_bits"}, 32'(bits), 32'(exp_bits));
    wait_done(80, seen, errv, waited);
    check_eq({pfx, "_done"}, 32'(seen), 32'd1);
    check_eq({pfx, "_err"}, 32'(errv), 32'(exp_err));
    check_eq({pfx, "_oe_at_done"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check_eq({pfx, "_ready_at_done"}, 32'(tx_ready), 32'd1);
    @(negedge clk);
    check_eq({pfx, "_done_pulse"}, {30'd0, done, err}, 32'd0);
    check_eq({pfx, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic xfer(input string pfx, input logic [7:0] b, input bit ack,
                      input logic [9:0] exp_bits, input bit exp_err);
    int         n_oe;
    int         first_dat;
    logic [9:0] bits;
    send(b, 1'b0);
    inhibit_phase(n_oe, first_dat);
    check_eq({pfx, "_inhibit_len"}, 32'(n_oe), 32'(INH));
    check_eq({pfx, "_start_bit_cycle"}, 32'(first_dat), 32'(INH));
    check_eq({pfx, "_start_state"}, {29'd0, ps2_clk_oe, ps2_dat_oe, busy}, 32'b011);
    dev_clock(11, ack, bits);
    finish_checks(pfx, bits, exp_bits, exp_err);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int         n_oe;
    int         first_dat;
    logic [9:0] bits;
    bit         seen;
    logic       errv;
    int         waited;
    int         dn;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    cycles(3);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check_eq("rst_done_err", {30'd0, done, err}, 32'd0);
    rst = 1'b0;
    cycles(2);

    // 0xED: LSB-first 1,0,1,1,0,1,1,1, six ones -> parity 1, stop 1.
    xfer("ed", 8'hED, 1'b1, 10'h3ED, 1'b0);
    // 0x07: three ones -> parity 0.  0x00 -> parity 1.
    xfer("x07", 8'h07, 1'b1, 10'h207, 1'b0);
    xfer("x00", 8'h00, 1'b1, 10'h300, 1'b0);
    // 0xAA with NAK: four ones -> parity 1, err with done.
    xfer("nak", 8'hAA, 1'b0, 10'h3AA, 1'b1);

    // Device stops after data bit 3.
    send(8'hED, 1'b0);
    inhibit_phase(n_oe, first_dat);
    dev_clock(4, 1'b1, bits);
    check_eq("to_bits0_3", 32'(bits[3:0]), 32'hD);
    wait_done(400, seen, errv, waited);
    check_eq("to_done", 32'(seen), 32'd1);
    check_eq("to_err", 32'(errv), 32'd1);
    check_eq("to_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check_eq("to_window", 32'(waited >= 155 && waited <= 175), 32'd1);
    cycles(2);

    // tx_valid held high; tx_data changes mid-transfer and must wait for done.
    send(8'hED, 1'b1);
    inhibit_phase(n_oe, first_dat);
    check_eq("hold_inhibit_len", 32'(n_oe), 32'(INH));
    tx_data = 8'hF4;
    check_eq("hold_ready_low", 32'(tx_ready), 32'd0);
    dev_clock(11, 1'b1, bits);
    check_eq("hold_first_bits", 32'(bits), 32'h3ED);
    wait_done(80, seen, errv, waited);
    check_eq("hold_first_done", 32'(seen), 32'd1);
    check_eq("hold_first_err", 32'(errv), 32'd0);
    @(negedge clk);
    check_eq("hold_second_accept", {30'd0, tx_ready, busy}, 32'b01);
    tx_valid = 1'b0;
    inhibit_phase(n_oe, first_dat);
    check_eq("hold_second_inhibit", 32'(n_oe), 32'(INH));
    dev_clock(11, 1'b1, bits);
    // 0xF4: five ones -> parity 0.
    finish_checks("hold_f4", bits, 10'h2F4, 1'b0);

    // Reset during BITS: after two device edges bit1 of 0xED (0) is being driven.
    send(8'hED, 1'b0);
    inhibit_phase(n_oe, first_dat);
    dev_clock(2, 1'b1, bits);
    check_eq("mid_rst_pre", {30'd0, busy, ps2_dat_oe}, 32'b11);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check_eq("mid_rst_ready_busy", {30'd0, tx_ready, busy}, 32'b10);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    dn  = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_eq("mid_rst_no_done", 32'(dn), 32'd0);
    // 0xFF: eight ones -> parity 1.
    xfer("ff", 8'hFF, 1'b1, 10'h3FF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, is the number of clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, is the maximum number of clk cycles allowed between device clock falling edges, and for the final bus release (15 ms at 50 MHz).
REQ-003 clk  in  1  system clock; the only clock of the block.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 tx_data  in  8  command byte to the keyboard.
REQ-006 tx_valid  in  1  tx_data valid; accepted when tx_valid & tx_ready.
REQ-007 tx_ready  out  1  block is idle and can accept a byte.
REQ-008 ps2_clk_in / ps2_dat_in  in  1 each  raw PS/2 line levels, asynchronous.
REQ-009 ps2_clk_oe / ps2_dat_oe  out  1 each  1 = pull line low (open drain); 0 = release line.
REQ-010 busy  out  1  transfer in progress; the keyboard receiver ignores the bus while busy is high.
REQ-011 done  out  1  one-cycle pulse at the end of every accepted transfer.
REQ-012 err  out  1  one-cycle pulse coincident with done on a NAK or a timeout.

Function
REQ-013 ps2_clk_in and ps2_dat_in SHALL pass through 2-FF synchronizers; a device clock falling edge is synchronized 1 -> 0.
REQ-014 States: IDLE, INHIBIT, START, BITS, ACK, RELEASE.
REQ-015 IDLE: tx_ready=1, both oe=0. On handshake, the block latches the byte and computes odd parity (parity = ~^tx_data); the next state is INHIBIT and tx_ready=0 from the next cycle.
REQ-016 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. ps2_dat_oe rises to 1 in the last INHIBIT cycle. Then the next state is START.
REQ-017 START: ps2_clk_oe=0, ps2_dat_oe=1 (start bit 0). On the first falling edge, the block enters BITS with bit index 0.
REQ-018 BITS: on entry and after each falling edge, ps2_dat_oe = ~bit, where bit is as follows: indices 0-7 are data LSB first, index 8 is parity, index 9 is stop (1, line released). The falling edge after index 9 moves the block to ACK.
REQ-019 ACK: the synchronized data line is sampled in the cycle the ACK-entry falling edge is detected. Data 0 = ACK; data 1 = NAK (err latched). The next state is RELEASE.
REQ-020 RELEASE: the block waits until synchronized clk and data are both 1. It then pulses done (and err if latched) and returns to IDLE.
REQ-021 Timeout counter: cleared on each falling edge and on each state entry. If it reaches TIMEOUT_CYCLES in START, BITS, ACK or RELEASE, the block releases both lines, pulses done+err and enters IDLE.
REQ-022 busy = state != IDLE.
REQ-023 tx_valid while tx_ready=0 SHALL be ignored. No queuing.
REQ-024 Counters SHALL be sized $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1) and SHALL never wrap.
REQ-025 Falling edges seen in IDLE or INHIBIT SHALL be ignored.

Reset
REQ-026 On rst: state=IDLE, both oe=0, tx_ready=1, busy=0, done=0, err=0, counters=0, synchronizer flops=1.
REQ-027 rst mid-transfer SHALL release both lines on the first clk edge with rst high. No done pulse is generated.

Structure
REQ-028 A shared package ps2_pkg SHALL hold the state enum and the default INHIBIT/TIMEOUT constants.
REQ-029 One sub-module, ps2_line_sync (2-FF synchronizer plus falling-edge detect), SHALL be instantiated for ps2_clk and ps2_dat. The keyboard receiver reuses it.

Verification
All scenarios use INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200, and a device model clocking at 40 clk cycles per period.
REQ-030 Send 0xED, device ACKs -> data bits sampled on device rising edges are 1,0,1,1,0,1,1,1; parity 1; stop 1; done=1 and err=0 for 1 cycle; tx_ready returns to 1.
REQ-031 Send 0x07 -> parity bit 0. Send 0x00 -> parity bit 1. ps2_clk_oe is high for exactly 10 cycles in both cases.
REQ-032 Device holds data high at the ACK edge -> done=1 and err=1 in the same cycle; the block returns to IDLE.
REQ-033 Device stops clocking after data bit 3 -> within 200 cycles, done=err=1 and both oe=0.
REQ-034 tx_valid held high through a transfer with tx_data changed to 0xF4 mid-transfer -> the first byte is transmitted intact. 0xF4 is accepted only after done.
REQ-035 rst asserted during BITS -> next cycle both oe=0, tx_ready=1, no done. A following 0xFF transfer completes normally with parity 1.
